// File: rtl/rd_port_pkg.sv
// Shared types and constants for the read-port frame buffer.
// Sync word layout: magic in [31:16], sequence number in [15:0].
package rd_port_pkg;

    localparam logic [15:0] SYNC_MAGIC_DEF = 16'hD5A1;

    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 16;
    localparam int SEQ_HI   = 15;
    localparam int SEQ_LO   = 0;

    typedef enum logic {
        HUNT,
        COLLECT
    } asm_state_t;

    function automatic int nwords(input int width);
        return width / 32;
    endfunction

endpackage

// File: rtl/rd_port_frame_fifo.sv
// Show-ahead frame FIFO; head register holds the last frame once drained.
// Storage DEPTH includes the frame currently presented on head.
module rd_port_frame_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       avail,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign avail   = (count != '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && avail;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            head  <= '0;
        end else begin
            wptr  <= wptr + AW'(push_ok);
            rptr  <= rptr + AW'(pop_ok);
            count <= count + CW'(push_ok) - CW'(pop_ok);
            // On pop the next frame comes from memory, or straight from the
            // incoming push when the popped frame was the only one held.
            if (pop_ok) begin
                if (count > CW'(1))
                    head <= mem[rptr + AW'(1)];
                else if (push_ok)
                    head <= push_data;
            end else if (push_ok && !avail) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/rd_port_frame_buf.sv
// Assembles 32-bit host beats into sync-tagged frames for the read port,
// checks sync/sequence, and buffers frames in a show-ahead FIFO.
module rd_port_frame_buf
    import rd_port_pkg::*;
#(
    parameter int          RPORT_WIDTH = 512,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] SYNC_MAGIC  = SYNC_MAGIC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_wr_valid,
    output logic                     host_wr_ready,
    input  logic [31:0]              host_wr_data,
    input  logic                     read_inst_active,
    output logic [RPORT_WIDTH-1:0]   read_port_data,
    output logic                     rd_frame_avail,
    output logic [$clog2(DEPTH):0]   frame_count,
    input  logic                     clr_err,
    output logic                     err_sync,
    output logic                     err_seq,
    output logic                     err_underflow
);

    localparam int NWORDS = nwords(RPORT_WIDTH);
    localparam int BW     = $clog2(NWORDS);
    localparam logic [BW-1:0] LAST = BW'(NWORDS - 1);

    asm_state_t                  state;
    logic [BW-1:0]               beat_cnt;
    logic [15:0]                 exp_seq;
    logic [NWORDS-1:0][31:0]     frame_q;

    logic                        fifo_full;
    logic                        accept;
    logic                        is_sync;
    logic                        at_last;
    logic                        push;
    logic [RPORT_WIDTH-1:0]      push_data;
    logic                        set_sync;
    logic                        set_seq;
    logic                        set_uf;

    assign at_last = (state == COLLECT) && (beat_cnt == LAST);
    assign host_wr_ready = !(at_last && fifo_full);
    assign accept  = host_wr_valid && host_wr_ready;
    assign is_sync = (host_wr_data[MAGIC_HI:MAGIC_LO] == SYNC_MAGIC);

    assign push      = accept && at_last;
    assign push_data = {host_wr_data, frame_q[NWORDS-2:0]};

    assign set_sync = accept && (state == HUNT) && !is_sync;
    assign set_seq  = accept && (state == HUNT) && is_sync &&
                      (host_wr_data[SEQ_HI:SEQ_LO] != exp_seq);
    assign set_uf   = read_inst_active && !rd_frame_avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            beat_cnt <= '0;
            exp_seq  <= '0;
            frame_q  <= '0;
        end else if (accept) begin
            unique case (state)
                HUNT: begin
                    if (is_sync) begin
                        frame_q[0] <= host_wr_data;
                        beat_cnt   <= BW'(1);
                        exp_seq    <= host_wr_data[SEQ_HI:SEQ_LO] + 16'd1;
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    frame_q[beat_cnt] <= host_wr_data;
                    beat_cnt          <= beat_cnt + BW'(1);
                    if (beat_cnt == LAST)
                        state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    // A new error event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sync      <= 1'b0;
            err_seq       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_sync      <= (err_sync && !clr_err) || set_sync;
            err_seq       <= (err_seq && !clr_err) || set_seq;
            err_underflow <= (err_underflow && !clr_err) || set_uf;
        end
    end

    rd_port_frame_fifo #(
        .WIDTH (RPORT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (read_inst_active),
        .head      (read_port_data),
        .avail     (rd_frame_avail),
        .count     (frame_count),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_rd_port_frame_buf.sv
// Scoreboard bench for rd_port_frame_buf at RPORT_WIDTH=128, DEPTH=2.
module tb_rd_port_frame_buf;

    localparam int W = 128;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         host_wr_valid;
    logic         host_wr_ready;
    logic [31:0]  host_wr_data;
    logic         read_inst_active;
    logic [W-1:0] read_port_data;
    logic         rd_frame_avail;
    logic [1:0]   frame_count;
    logic         clr_err;
    logic         err_sync;
    logic         err_seq;
    logic         err_underflow;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] last_pop;

    always #5 clk = ~clk;

    rd_port_frame_buf #(
        .RPORT_WIDTH (W),
        .DEPTH       (D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_wr_valid    (host_wr_valid),
        .host_wr_ready    (host_wr_ready),
        .host_wr_data     (host_wr_data),
        .read_inst_active (read_inst_active),
        .read_port_data   (read_port_data),
        .rd_frame_avail   (rd_frame_avail),
        .frame_count      (frame_count),
        .clr_err          (clr_err),
        .err_sync         (err_sync),
        .err_seq          (err_seq),
        .err_underflow    (err_underflow)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        host_wr_valid = 1'b0;
        read_inst_active = 1'b0;
        clr_err = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        @(negedge clk);
        host_wr_valid = 1'b1;
        host_wr_data  = d;
        n = 0;
        while (!host_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 host_wr_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] mk_frame(input logic [15:0] seq,
                                              input logic [31:0] base);
        logic [W-1:0] f;
        f[31:0] = {16'hD5A1, seq};
        for (int i = 1; i < 4; i++)
            f[32*i +: 32] = base + 32'(i);
        return f;
    endfunction

    task automatic send_frame(input logic [15:0] seq,
                              input logic [31:0] base);
        logic [W-1:0] f;
        f = mk_frame(seq, base);
        sb.push_back(f);
        for (int i = 0; i < 4; i++)
            send_beat(f[32*i +: 32]);
    endtask

    task automatic pop_frame();
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            last_pop = sb.pop_front();
            check("head", read_port_data, last_pop);
            check("avail_pre", W'(rd_frame_avail), W'(1));
        end
        read_inst_active = 1'b1;
        @(posedge clk);
        #1 read_inst_active = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_data = '0;
        read_inst_active = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", read_port_data, '0);
        check("rst_avail", W'(rd_frame_avail), '0);
        check("rst_count", W'(frame_count), '0);
        check("rst_errs", W'({err_sync, err_seq, err_underflow}), '0);
        rst = 1'b0;

        // underflow on empty buffer
        @(negedge clk);
        read_inst_active = 1'b1;
        @(posedge clk);
        #1 read_inst_active = 1'b0;
        @(negedge clk);
        check("uf_set", W'(err_underflow), W'(1));
        check("uf_data", read_port_data, '0);
        pulse_clr();
        @(negedge clk);
        check("uf_clr", W'(err_underflow), '0);

        // basic frame assembly
        sb.push_back({32'h33333333, 32'h22222222, 32'h11111111, 32'hD5A10000});
        send_beat(32'hD5A10000);
        send_beat(32'h11111111);
        send_beat(32'h22222222);
        send_beat(32'h33333333);
        @(negedge clk);
        check("f1_data", read_port_data,
              128'h33333333_22222222_11111111_D5A10000);
        check("f1_avail", W'(rd_frame_avail), W'(1));
        check("f1_count", W'(frame_count), W'(1));
        check("f1_errs", W'({err_sync, err_seq, err_underflow}), '0);
        pop_frame();
        @(negedge clk);
        check("hold_data", read_port_data, last_pop);
        check("hold_avail", W'(rd_frame_avail), '0);
        check("hold_count", W'(frame_count), '0);

        // garbage before sync
        do_reset();
        send_beat(32'h12345678);
        send_frame(16'h0000, 32'hA0000000);
        @(negedge clk);
        check("sync_err", W'(err_sync), W'(1));
        check("sync_noseq", W'(err_seq), '0);
        pop_frame();
        pulse_clr();
        @(negedge clk);
        check("sync_clr", W'(err_sync), '0);

        // sequence checking and wrap
        do_reset();
        send_frame(16'h0000, 32'hB0000000);
        pop_frame();
        send_frame(16'h0005, 32'hB1000000);
        @(negedge clk);
        check("seq_bad", W'(err_seq), W'(1));
        pop_frame();
        pulse_clr();
        send_frame(16'h0006, 32'hB2000000);
        @(negedge clk);
        check("seq_ok6", W'(err_seq), '0);
        pop_frame();
        send_frame(16'hFFFF, 32'hB3000000);
        pop_frame();
        pulse_clr();
        send_frame(16'h0000, 32'hB4000000);
        @(negedge clk);
        check("seq_wrap", W'(err_seq), '0);
        pop_frame();

        // backpressure only on committing beat
        do_reset();
        send_frame(16'h0000, 32'hC0000000);
        send_frame(16'h0001, 32'hC1000000);
        @(negedge clk);
        check("full_count", W'(frame_count), W'(2));
        begin
            logic [W-1:0] f3;
            f3 = mk_frame(16'h0002, 32'hC2000000);
            sb.push_back(f3);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("rdy_part", W'(host_wr_ready), W'(1));
                send_beat(f3[32*i +: 32]);
            end
            @(negedge clk);
            host_wr_valid = 1'b1;
            host_wr_data  = f3[127:96];
            check("rdy_stall", W'(host_wr_ready), '0);
            last_pop = sb.pop_front();
            check("full_head", read_port_data, last_pop);
            read_inst_active = 1'b1;
            @(posedge clk);
            #1 read_inst_active = 1'b0;
            @(negedge clk);
            check("rdy_resume", W'(host_wr_ready), W'(1));
            @(posedge clk);
            #1 host_wr_valid = 1'b0;
            @(negedge clk);
            check("full_count2", W'(frame_count), W'(2));
        end
        pop_frame();
        pop_frame();

        // reset mid-frame
        send_frame(16'h0003, 32'hD0000000);
        send_beat(32'hD5A10004);
        send_beat(32'hD1000001);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("mrst_data", read_port_data, '0);
        check("mrst_avail", W'(rd_frame_avail), '0);
        check("mrst_count", W'(frame_count), '0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'h0000, 32'hE0000000);
        @(negedge clk);
        check("mrst_seq", W'(err_seq), '0);
        check("mrst_sync", W'(err_sync), '0);
        pop_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
